cfu_add_sequencer: RTL

CFU-facing controller that owns the shared quantized-add unit (elementwise int8 add, four lanes per word). Host software pushes packed operand-word pairs into an input FIFO. The sequencer issues them to the add unit one at a time and collects the packed results into a result FIFO, which the host drains. Configuration commands for the add unit are forwarded only after all queued work has retired, so parameter changes never land mid-stream.

---
 rtl/cfu_add_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/cfu_add_sequencer.sv
// Host-facing controller for the shared int8 add unit. Operand pairs are queued, issued one at
// a time, and their results are queued for the host. Config commands are forwarded only once idle.
module cfu_add_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        add_cmd_valid,
  input  logic        add_cmd_ready,
  output logic [9:0]  add_function_id,
  output logic [31:0] add_inputs_0,
  output logic [31:0] add_inputs_1,
  input  logic        add_rsp_valid,
  output logic        add_rsp_ready,
  input  logic [31:0] add_rsp_outputs_0
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OP_CFG0 = 7'd0, OP_CFG1 = 7'd1, OP_PUSH = 7'd2,
                         OP_POP = 7'd3, OP_STATUS = 7'd4, OP_CLEAR = 7'd5;

  typedef enum logic [2:0] {H_IDLE, H_RSP, H_DRAIN, H_FWD, H_FWAIT, H_POPW, H_CLR} host_state_t;
  typedef enum logic [1:0] {E_IDLE, E_ISSUE, E_WAIT} eng_state_t;

  host_state_t r_hstate, w_hstate_next;
  eng_state_t  r_estate, w_estate_next;

  logic [63:0]   r_in_mem [DEPTH];
  logic [31:0]   r_res_mem [DEPTH];
  logic [AW-1:0] r_in_wp, r_in_rp, r_res_wp, r_res_rp;
  logic [CW-1:0] r_in_count, r_res_count;
  logic          r_overflow;
  logic [31:0]   r_rsp_data, w_rsp_data_next;
  logic [6:0]    r_fwd_f7;
  logic [31:0]   r_fwd_in0, r_fwd_in1;

  logic [6:0]    w_f7;
  logic          w_cmd_fire, w_eng_busy, w_in_empty, w_in_full, w_res_empty, w_res_full;
  logic          w_in_push, w_in_pop, w_res_push, w_res_pop, w_flush;
  logic          w_ovf_set, w_ovf_clr, w_fwd_load, w_host_owns_add;
  logic [63:0]   w_in_head;
  logic [31:0]   w_res_head, w_status;
  logic [CW-1:0] w_push_cnt;
  logic          w_unused;

  assign w_unused   = ^cmd_payload_function_id[2:0];
  assign w_f7       = cmd_payload_function_id[9:3];
  assign cmd_ready  = (r_hstate == H_IDLE) && !rsp_valid;
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign rsp_valid  = (r_hstate == H_RSP);
  assign rsp_payload_outputs_0 = r_rsp_data;
  assign add_rsp_ready = 1'b1;

  assign w_eng_busy  = (r_estate != E_IDLE);
  assign w_in_empty  = (r_in_count == '0);
  assign w_in_full   = (r_in_count == CW'(DEPTH));
  assign w_res_empty = (r_res_count == '0);
  assign w_res_full  = (r_res_count == CW'(DEPTH));
  assign w_in_head   = r_in_mem[r_in_rp];
  assign w_res_head  = r_res_mem[r_res_rp];
  assign w_in_pop    = (r_estate == E_ISSUE) && add_cmd_ready;
  assign w_res_push  = (r_estate == E_WAIT) && add_rsp_valid;
  assign w_push_cnt  = r_in_count + CW'(1) - CW'(w_in_pop);
  assign w_status    = {8'h00, 8'(r_in_count), 8'(r_res_count), 6'h00, w_eng_busy, r_overflow};
  // The host blocks new issues while it forwards a config or is flushing the queues.
  assign w_host_owns_add = (r_hstate == H_FWD) || (r_hstate == H_FWAIT) || (r_hstate == H_CLR);

  always_comb begin
    w_hstate_next   = r_hstate;
    w_rsp_data_next = r_rsp_data;
    w_in_push = 1'b0;
    w_res_pop = 1'b0;
    w_flush   = 1'b0;
    w_ovf_set = 1'b0;
    w_ovf_clr = 1'b0;
    w_fwd_load = 1'b0;
    case (r_hstate)
      H_IDLE: if (w_cmd_fire) begin
        case (w_f7)
          OP_CFG0, OP_CFG1: begin
            w_fwd_load = 1'b1;
            w_rsp_data_next = 32'h0;
            w_hstate_next = H_DRAIN;
          end
          OP_PUSH: begin
            if (w_in_full) begin
              w_ovf_set = 1'b1;
              w_rsp_data_next = 32'hFFFF_FFFF;
            end else begin
              w_in_push = 1'b1;
              w_rsp_data_next = 32'(w_push_cnt);
            end
            w_hstate_next = H_RSP;
          end
          OP_POP: begin
            if (!w_res_empty) begin
              w_res_pop = 1'b1;
              w_rsp_data_next = w_res_head;
              w_hstate_next = H_RSP;
            end else if (!w_in_empty || w_eng_busy) begin
              w_hstate_next = H_POPW;
            end else begin
              w_rsp_data_next = 32'h0;
              w_hstate_next = H_RSP;
            end
          end
          OP_STATUS: begin
            w_ovf_clr = 1'b1;
            w_rsp_data_next = w_status;
            w_hstate_next = H_RSP;
          end
          OP_CLEAR: begin
            w_rsp_data_next = 32'h0;
            w_hstate_next = H_CLR;
          end
          default: begin
            w_rsp_data_next = 32'hDEAD_0000;
            w_hstate_next = H_RSP;
          end
        endcase
      end
      H_DRAIN: if (w_in_empty && !w_eng_busy) w_hstate_next = H_FWD;
      H_FWD:   if (add_cmd_ready) w_hstate_next = H_FWAIT;
      H_FWAIT: if (add_rsp_valid) w_hstate_next = H_RSP;
      H_POPW: if (!w_res_empty) begin
        w_res_pop = 1'b1;
        w_rsp_data_next = w_res_head;
        w_hstate_next = H_RSP;
      end
      H_CLR: if (!w_eng_busy) begin
        w_flush = 1'b1;
        w_hstate_next = H_RSP;
      end
      H_RSP:   if (rsp_ready) w_hstate_next = H_IDLE;
      default: w_hstate_next = H_IDLE;
    endcase
  end

  always_comb begin
    w_estate_next = r_estate;
    case (r_estate)
      E_IDLE:  if (!w_in_empty && !w_res_full && !w_host_owns_add) w_estate_next = E_ISSUE;
      E_ISSUE: if (add_cmd_ready) w_estate_next = E_WAIT;
      E_WAIT:  if (add_rsp_valid) w_estate_next = E_IDLE;
      default: w_estate_next = E_IDLE;
    endcase
  end

  always_comb begin
    add_cmd_valid   = 1'b0;
    add_function_id = 10'h000;
    add_inputs_0    = 32'h0;
    add_inputs_1    = 32'h0;
    if (r_hstate == H_FWD) begin
      add_cmd_valid   = 1'b1;
      add_function_id = {r_fwd_f7, 3'b000};
      add_inputs_0    = r_fwd_in0;
      add_inputs_1    = r_fwd_in1;
    end else if (r_estate == E_ISSUE) begin
      add_cmd_valid   = 1'b1;
      add_function_id = {OP_PUSH, 3'b000};
      add_inputs_0    = w_in_head[63:32];
      add_inputs_1    = w_in_head[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hstate   <= H_IDLE;
      r_estate   <= E_IDLE;
      r_rsp_data <= 32'h0;
      r_overflow <= 1'b0;
      r_fwd_f7   <= 7'h0;
      r_fwd_in0  <= 32'h0;
      r_fwd_in1  <= 32'h0;
    end else begin
      r_hstate   <= w_hstate_next;
      r_estate   <= w_estate_next;
      r_rsp_data <= w_rsp_data_next;
      if (w_flush || w_ovf_clr) r_overflow <= 1'b0;
      else if (w_ovf_set)       r_overflow <= 1'b1;
      if (w_fwd_load) begin
        r_fwd_f7  <= w_f7;
        r_fwd_in0 <= cmd_payload_inputs_0;
        r_fwd_in1 <= cmd_payload_inputs_1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_wp <= '0; r_in_rp <= '0; r_in_count <= '0;
      r_res_wp <= '0; r_res_rp <= '0; r_res_count <= '0;
    end else if (w_flush) begin
      r_in_wp <= '0; r_in_rp <= '0; r_in_count <= '0;
      r_res_wp <= '0; r_res_rp <= '0; r_res_count <= '0;
    end else begin
      if (w_in_push)  r_in_wp  <= r_in_wp + AW'(1);
      if (w_in_pop)   r_in_rp  <= r_in_rp + AW'(1);
      if (w_res_push) r_res_wp <= r_res_wp + AW'(1);
      if (w_res_pop)  r_res_rp <= r_res_rp + AW'(1);
      r_in_count  <= r_in_count + CW'(w_in_push) - CW'(w_in_pop);
      r_res_count <= r_res_count + CW'(w_res_push) - CW'(w_res_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wp]   <= {cmd_payload_inputs_0, cmd_payload_inputs_1};
    if (w_res_push) r_res_mem[r_res_wp] <= add_rsp_outputs_0;
  end
endmodule
